// File: rtl/uc_multiciclo.sv
`default_nettype none
// uc_multiciclo: multi-cycle control unit for the microc datapath.
// Runs each instruction as FETCH then EXEC, or FETCH/CMP/SKIP for skips, and sticks in HALT on illegal opcodes.
module uc_multiciclo #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             zero,
  input  logic             carry,
  output logic             s_inc,
  output logic             s_skip,
  output logic             s_inm,
  output logic             we,
  output logic [2:0]       ALUOp,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    CMP   = 3'd2,
    SKIP  = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t     state, state_next;
  logic [5:0] ir;
  logic       zf, cf;
  logic       op_jr, op_skip, op_illegal;

  // 00xxxx covers both LI and the ALU group; 1111xx holds the three skips plus JR.
  always_comb begin
    op_jr      = (Opcode == 6'b111111);
    op_skip    = (Opcode[5:2] == 4'b1111) && !op_jr;
    op_illegal = (Opcode[5:4] != 2'b00) && !op_skip && !op_jr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      ir          <= 6'b000000;
      zf          <= 1'b0;
      cf          <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_next;
      if (state == FETCH)
        ir <= Opcode;
      if (state == CMP) begin
        zf <= zero;
        cf <= carry;
      end
      if (state == EXEC || state == SKIP)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = FETCH;
    pc_en      = 1'b0;
    we         = 1'b0;
    s_inc      = 1'b1;
    s_skip     = 1'b0;
    s_inm      = 1'b0;
    ALUOp      = 3'b000;
    halted     = 1'b0;
    case (state)
      FETCH: begin
        if (op_illegal)
          state_next = HALT;
        else if (op_skip)
          state_next = CMP;
        else
          state_next = EXEC;
      end
      EXEC: begin
        pc_en = 1'b1;
        if (ir[5:3] == 3'b000) begin
          we    = 1'b1;
          s_inm = 1'b1;
        end else if (ir[5:3] == 3'b001) begin
          we    = 1'b1;
          ALUOp = ir[2:0];
        end else if (ir == 6'b111111) begin
          s_inc = 1'b0;
        end
      end
      CMP: begin
        ALUOp      = 3'b011;
        state_next = SKIP;
      end
      SKIP: begin
        ALUOp = 3'b011;
        pc_en = 1'b1;
        // Only the flags captured in CMP decide the skip, never the live ALU flags.
        case (ir[1:0])
          2'b00:   s_skip = ~zf;
          2'b01:   s_skip = zf;
          2'b10:   s_skip = cf;
          default: s_skip = 1'b0;
        endcase
      end
      HALT: begin
        halted     = 1'b1;
        state_next = HALT;
      end
      default: state_next = FETCH;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/uc_multiciclo.md
Name: uc_multiciclo

Overview:
- Multi-cycle control unit for the `microc` datapath: the opposite end of the datapath's control interface.
- Consumes `Opcode`, `zero` and `carry` from the datapath and drives `s_inc`, `s_skip`, `s_inm`, `we`, `ALUOp` and a PC write enable back to it.
- Sequences each instruction through FETCH/EXEC (plus a compare cycle for skips) and halts on illegal opcodes.

Parameters:
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- Opcode  input  6  instruction opcode field from the datapath's instruction memory.
- zero  input  1  ALU zero flag from the datapath, combinational.
- carry  input  1  ALU carry flag from the datapath, combinational.
- s_inc  output  1  PC source: 1 = PC+1/+2 path, 0 = PC+displacement (JR).
- s_skip  output  1  with s_inc=1: 1 = PC+2, 0 = PC+1.
- s_inm  output  1  register-file write data: 1 = immediate, 0 = ALU result.
- we  output  1  register-file write enable.
- ALUOp  output  3  ALU operation select.
- pc_en  output  1  PC register load enable.
- halted  output  1  high while in HALT.
- instr_count  output  CNT_W  retired-instruction counter.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset=0 asynchronously forces: state=FETCH, ir=000000, zf=0, cf=0, instr_count=0.
  - Outputs take their defaults immediately on reset assertion, and reset mid-instruction aborts that instruction with no PC or register write.
- Output defaults, driven in every state unless overridden below: pc_en=0, we=0, s_inc=1, s_skip=0, s_inm=0, ALUOp=000, halted=0.
- Opcode decode (6 bits):
  - 000xxx LI.
  - 001aaa ALU register op; ALUOp=aaa.
  - 111100 SKIPNE.
  - 111101 SKIPEQ.
  - 111110 SKIPC.
  - 111111 JR.
  - Every other code (010000–111011) is illegal.
- FETCH:
  - Outputs are at their defaults.
  - At the clock edge: ir<=Opcode.
  - Next state: HALT if Opcode is illegal, CMP if it is a skip, otherwise EXEC.
- EXEC (decoded from ir):
  - pc_en=1.
  - LI: we=1, s_inm=1, s_inc=1, s_skip=0.
  - ALU: we=1, s_inm=0, ALUOp=ir[2:0].
  - JR: s_inc=0, we=0.
  - Next state: FETCH. instr_count increments at the exit edge.
- CMP:
  - ALUOp=011 (subtract), we=0, pc_en=0.
  - At the clock edge: zf<=zero, cf<=carry.
  - Next state: SKIP.
- SKIP:
  - ALUOp=011, pc_en=1, s_inc=1.
  - s_skip is taken from the registered flags: SKIPNE gives ~zf, SKIPEQ gives zf, SKIPC gives cf.
  - Next state: FETCH. instr_count increments at the exit edge.
- HALT:
  - halted=1, pc_en=0, we=0, all other outputs at their defaults.
  - Sticky; only reset leaves HALT. instr_count is frozen.
- Latency:
  - LI/ALU/JR take 2 cycles; skips take 3 cycles.
  - Exactly one pc_en pulse per retired instruction.
  - The Opcode input is sampled only at the end of FETCH; changes in other states are ignored.
- instr_count:
  - Unsigned, wraps from 2^CNT_W−1 to 0.
  - No saturation.
- Flags:
  - zf/cf are updated only in CMP.
  - zero/carry changes in other states have no effect on s_skip.
- Outputs are Moore outputs of (state, ir, zf, cf): glitch-free relative to the Opcode input.
- FSM encoding is free, but every unused encoding must recover to FETCH.

Test Plan:
- Reset, then hold reset=1 with Opcode=000001 (LI).
  - Cycle 0 (FETCH): pc_en=0, we=0.
  - Cycle 1 (EXEC): pc_en=1, we=1, s_inm=1, s_inc=1, s_skip=0.
  - Then instr_count=1.
- Opcode=001010 (ADD).
  - EXEC: ALUOp=010, we=1, s_inm=0, pc_en=1.
  - Opcode=001011 likewise gives ALUOp=011.
- Opcode=111100 (SKIPNE) with zero=0 during CMP, then zero forced to 1 during SKIP.
  - CMP: ALUOp=011, pc_en=0.
  - SKIP: s_skip=1, pc_en=1 (registered flag used, not live zero).
  - Repeat with zero=1 in CMP → s_skip=0.
- Opcode=111111 (JR).
  - EXEC: s_inc=0, pc_en=1, we=0.
  - Opcode=111110 with carry=1 in CMP → s_skip=1.
- Opcode=010101 (illegal).
  - Next cycle: halted=1, pc_en=0, we=0, and the state persists for 10 cycles whatever the Opcode.
  - Assert reset=0 → halted=0, instr_count=0, state FETCH.
- CNT_W=2 with 5 LI instructions → instr_count sequence 1, 2, 3, 0, 1.
- Assert reset=0 mid-CMP → s_skip=0 and pc_en=0 immediately, with no pc_en pulse for that instruction.
